axi_lite_ram_bist: RTL and testbench

AXI-Lite master controller that sequences the shared AXI-Lite block RAM for self-test and initialisation. It fills a word range with a generated pattern and/or reads the range back and compares. It runs one outstanding transaction at a time and reports error count and first failing address. It sits in place of, or muxed with, the verification master in front of the RAM slave.

---
 rtl/axi_lite_bist_pkg.sv | 15 +
 rtl/axi_lite_ram_bist.sv | 129 ++++++++++++
 tb/tb_axi_lite_ram_bist.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_bist_pkg.sv
// axi_lite_bist_pkg: shared types, response codes and pattern generator for the RAM BIST master
package axi_lite_bist_pkg;
    localparam int BIST_DATA_W = 32;
    localparam int BIST_CNT_W  = 16;
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, FINISH} state_e;
    typedef enum logic [1:0] {MODE_FILL = 2'd0, MODE_CHECK = 2'd1, MODE_FILL_CHECK = 2'd2} mode_e;
    function automatic logic [BIST_DATA_W-1:0] expected_data(
        input logic [BIST_DATA_W-1:0] seed,
        input logic [BIST_CNT_W-1:0]  index,
        input logic                   pattern_sel
    );
        return pattern_sel ? seed + BIST_DATA_W'(index) : seed;
    endfunction
endpackage

// File: rtl/axi_lite_ram_bist.sv
// axi_lite_ram_bist: AXI-Lite master that fills and/or verifies a RAM word range, one transaction at a time
import axi_lite_bist_pkg::*;

module axi_lite_ram_bist #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = BIST_DATA_W,
    parameter int CNT_W  = BIST_CNT_W
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [CNT_W-1:0]    num_words,
    input  logic                pattern_sel,
    input  logic [DATA_W-1:0]   seed,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    err_cnt,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic                resp_err,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready
);
    state_e              state, next_state;
    mode_e               mode_q;
    logic [ADDR_W-1:0]   base_q, cur_addr;
    logic [CNT_W-1:0]    num_q, idx;
    logic                psel_q, aw_done, w_done;
    logic [DATA_W-1:0]   seed_q, exp_data;
    logic                aw_hs, w_hs, wr_sent, last, word_done, wr_err, rd_err, rd_resp_bad;

    assign aw_hs       = m_axi_awvalid && m_axi_awready;
    assign w_hs        = m_axi_wvalid && m_axi_wready;
    assign wr_sent     = (aw_done || aw_hs) && (w_done || w_hs);
    assign last        = idx == num_q - CNT_W'(1);
    assign cur_addr    = base_q + (ADDR_W'(idx) << 2);
    assign exp_data    = expected_data(seed_q, idx, psel_q);
    assign word_done   = (state == WR_RESP && m_axi_bvalid) || (state == RD_RESP && m_axi_rvalid);
    assign rd_resp_bad = state == RD_RESP && m_axi_rvalid && m_axi_rresp != AXI_RESP_OKAY;
    assign wr_err      = state == WR_RESP && m_axi_bvalid && m_axi_bresp != AXI_RESP_OKAY;
    assign rd_err      = rd_resp_bad || (state == RD_RESP && m_axi_rvalid && m_axi_rdata != exp_data);

    assign m_axi_awaddr = cur_addr;
    assign m_axi_araddr = cur_addr;
    assign m_axi_wdata  = exp_data;
    assign m_axi_wstrb  = '1;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = num_words == '0 ? FINISH : mode == 2'd1 ? RD_REQ : WR_REQ;
            WR_REQ:  if (wr_sent) next_state = WR_RESP;
            WR_RESP: if (m_axi_bvalid) next_state = !last ? WR_REQ : mode_q == MODE_FILL_CHECK ? RD_REQ : FINISH;
            RD_REQ:  if (m_axi_arready) next_state = RD_RESP;
            RD_RESP: if (m_axi_rvalid) next_state = last ? FINISH : RD_REQ;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        m_axi_awvalid = state == WR_REQ && !aw_done;
        m_axi_wvalid  = state == WR_REQ && !w_done;
        m_axi_bready  = state == WR_RESP;
        m_axi_arvalid = state == RD_REQ;
        m_axi_rready  = state == RD_RESP;
        busy          = state inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP};
        done          = state == FINISH;
    end

    // Run arguments are frozen at start so the caller may change them while busy
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mode_q         <= MODE_FILL;
            base_q         <= '0;
            num_q          <= '0;
            psel_q         <= 1'b0;
            seed_q         <= '0;
            idx            <= '0;
            aw_done        <= 1'b0;
            w_done         <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            resp_err       <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                mode_q         <= mode == 2'd0 ? MODE_FILL : mode == 2'd1 ? MODE_CHECK : MODE_FILL_CHECK;
                base_q         <= {base_addr[ADDR_W-1:2], 2'b00};
                num_q          <= num_words;
                psel_q         <= pattern_sel;
                seed_q         <= seed;
                idx            <= '0;
                err_cnt        <= '0;
                first_err_addr <= '0;
                resp_err       <= 1'b0;
            end
            if (state == WR_REQ) begin
                aw_done <= !wr_sent && (aw_done || aw_hs);
                w_done  <= !wr_sent && (w_done || w_hs);
            end
            if (word_done) idx <= last ? '0 : idx + CNT_W'(1);
            if (wr_err || rd_err) begin
                err_cnt <= &err_cnt ? err_cnt : err_cnt + CNT_W'(1);
                if (err_cnt == '0) first_err_addr <= cur_addr;
            end
            if (wr_err || rd_resp_bad) resp_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_axi_lite_ram_bist.sv
// tb_axi_lite_ram_bist: scoreboard bench with a behavioural AXI-Lite RAM slave
module tb_axi_lite_ram_bist;
    logic        aclk = 1'b0, aresetn = 1'b0;
    logic        start = 1'b0, pattern_sel = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] base_addr = '0, seed = '0;
    logic [15:0] num_words = '0;
    logic        busy, done, resp_err;
    logic [15:0] err_cnt;
    logic [31:0] first_err_addr;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready = 1'b1, wready = 1'b1, arready = 1'b1;
    logic        bvalid = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = 2'b00, rresp = 2'b00;
    logic [31:0] rdata = '0;

    always #5 aclk = ~aclk;

    axi_lite_ram_bist dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .mode(mode), .base_addr(base_addr),
        .num_words(num_words), .pattern_sel(pattern_sel), .seed(seed), .busy(busy), .done(done),
        .err_cnt(err_cnt), .first_err_addr(first_err_addr), .resp_err(resp_err),
        .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    typedef struct {logic [31:0] addr; logic [31:0] data;} wr_t;
    typedef struct {logic [15:0] err; logic [31:0] first; logic resp;} res_t;
    wr_t         exp_wr[$];
    logic [31:0] exp_rd[$];
    res_t        exp_res[$];
    int          total = 0, bad = 0;
    int          done_cnt = 0, act_cnt = 0, wr_cnt = 0, rd_count = 0;
    int          aw_hold = 0, rd_err_idx = 0;
    logic [31:0] mem [1024];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Slave: snapshot handshakes at negedge, react just after the following posedge
    initial begin
        logic s_aw, s_w, s_b, s_ar, s_r, s_awv, have_aw, have_w;
        logic [31:0] s_awaddr, s_wdata, s_araddr, wa, wd;
        wr_t e;
        have_aw = 1'b0;
        have_w  = 1'b0;
        wa = '0;
        wd = '0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        forever begin
            @(negedge aclk);
            s_aw = awvalid && awready; s_w = wvalid && wready; s_b = bvalid && bready;
            s_ar = arvalid && arready; s_r = rvalid && rready; s_awv = awvalid;
            s_awaddr = awaddr; s_wdata = wdata; s_araddr = araddr;
            @(posedge aclk);
            #1;
            if (!aresetn) begin
                have_aw = 1'b0; have_w = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
                awready = aw_hold == 0;
            end else begin
                if (s_aw) begin have_aw = 1'b1; wa = s_awaddr; end
                if (s_w) begin
                    have_w = 1'b1; wd = s_wdata;
                    check("wstrb", wstrb, 4'hF);
                end
                if (s_b) bvalid = 1'b0;
                if (have_aw && have_w && !bvalid) begin
                    if (exp_wr.size() == 0) check("wr_unexpected", 1, 0);
                    else begin
                        e = exp_wr.pop_front();
                        check("wr_addr", wa, e.addr);
                        check("wr_data", wd, e.data);
                    end
                    mem[wa[11:2]] = wd;
                    wr_cnt++;
                    bvalid = 1'b1; bresp = 2'b00;
                    have_aw = 1'b0; have_w = 1'b0;
                end
                if (s_awv && !s_aw && aw_hold > 0) aw_hold--;
                awready = aw_hold == 0;
                if (s_r) rvalid = 1'b0;
                if (s_ar) begin
                    rd_count++;
                    if (exp_rd.size() == 0) check("rd_unexpected", 1, 0);
                    else check("rd_addr", s_araddr, exp_rd.pop_front());
                    rvalid = 1'b1;
                    rresp  = rd_count == rd_err_idx ? 2'b10 : 2'b00;
                    rdata  = rd_count == rd_err_idx ? ~mem[s_araddr[11:2]] : mem[s_araddr[11:2]];
                end
            end
        end
    end

    initial begin
        res_t r;
        forever begin
            @(negedge aclk);
            if (awvalid || wvalid || arvalid) act_cnt++;
            if (done) begin
                done_cnt++;
                check("busy_at_done", busy, 0);
                if (exp_res.size() == 0) check("done_unexpected", 1, 0);
                else begin
                    r = exp_res.pop_front();
                    check("err_cnt", err_cnt, r.err);
                    check("first_err_addr", first_err_addr, r.first);
                    check("resp_err", resp_err, r.resp);
                end
            end
        end
    end

    task automatic push_exp(input logic [1:0] md, input logic [31:0] base, input int n,
                            input logic ps, input logic [31:0] sd);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = {base[31:2], 2'b00} + 32'(4 * i);
            if (md != 2'd1) exp_wr.push_back('{a, ps ? sd + 32'(i) : sd});
            if (md != 2'd0) exp_rd.push_back(a);
        end
    endtask

    task automatic issue(input logic [1:0] md, input logic [31:0] base, input int n,
                         input logic ps, input logic [31:0] sd);
        @(negedge aclk);
        mode = md; base_addr = base; num_words = 16'(n); pattern_sel = ps; seed = sd;
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
    endtask

    task automatic run(input logic [1:0] md, input logic [31:0] base, input int n, input logic ps,
                       input logic [31:0] sd, input logic [15:0] e_err, input logic [31:0] e_first,
                       input logic e_resp);
        int d0;
        push_exp(md, base, n, ps, sd);
        exp_res.push_back('{e_err, e_first, e_resp});
        d0 = done_cnt;
        issue(md, base, n, ps, sd);
        for (int c = 0; c < 2000 && done_cnt == d0; c++) @(negedge aclk);
        check("run_done", done_cnt - d0, 1);
    endtask

    initial begin
        int d0, a0, awv, wv, early, addr_bad, w0;
        logic aw_seen, w_seen, found;
        repeat (3) @(negedge aclk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_first", first_err_addr, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
        aresetn = 1'b1;

        run(2'd0, 32'h100, 4, 1'b1, 32'hA5A50000, 0, 0, 0);
        check("mem_10c", mem[32'h10C >> 2], 32'hA5A50003);
        run(2'd1, 32'h100, 4, 1'b1, 32'hA5A50000, 0, 0, 0);
        mem[32'h108 >> 2] = 32'hDEADBEEF;
        run(2'd1, 32'h100, 4, 1'b1, 32'hA5A50000, 1, 32'h108, 0);

        a0 = act_cnt;
        d0 = done_cnt;
        exp_res.push_back('{16'd0, 32'd0, 1'b0});
        issue(2'd2, 32'h200, 0, 1'b0, 32'h0);
        check("zero_done_timing", done, 1);
        repeat (3) @(negedge aclk);
        check("zero_done_count", done_cnt - d0, 1);
        check("zero_no_traffic", act_cnt - a0, 0);

        aw_hold = 5;
        @(negedge aclk);
        push_exp(2'd0, 32'h300, 1, 1'b0, 32'h12345678);
        exp_res.push_back('{16'd0, 32'd0, 1'b0});
        d0 = done_cnt;
        awv = 0; wv = 0; early = 0; addr_bad = 0; aw_seen = 1'b0; w_seen = 1'b0;
        issue(2'd0, 32'h300, 1, 1'b0, 32'h12345678);
        for (int c = 0; c < 40 && done_cnt == d0; c++) begin
            if (bready && !(aw_seen && w_seen)) early++;
            if (awvalid) begin awv++; if (awaddr != 32'h300) addr_bad++; end
            if (wvalid) wv++;
            if (awvalid && awready) aw_seen = 1'b1;
            if (wvalid && wready) w_seen = 1'b1;
            if (c == 2) begin mode = 2'd1; num_words = 16'd7; start = 1'b1; end
            else start = 1'b0;
            @(negedge aclk);
        end
        start = 1'b0;
        check("bp_done", done_cnt - d0, 1);
        check("bp_awvalid_cycles", awv, 6);
        check("bp_wvalid_cycles", wv, 1);
        check("bp_awaddr_stable", addr_bad, 0);
        check("bp_bready_early", early, 0);
        repeat (10) @(negedge aclk);
        check("bp_second_start_ignored", done_cnt - d0, 1);
        check("bp_idle", busy, 0);

        push_exp(2'd2, 32'h400, 8, 1'b1, 32'h1000);
        w0 = wr_cnt;
        found = 1'b0;
        issue(2'd2, 32'h400, 8, 1'b1, 32'h1000);
        for (int c = 0; c < 200 && !found; c++) begin
            if (wr_cnt >= w0 + 1 && awvalid) found = 1'b1;
            else @(negedge aclk);
        end
        check("mid_reached_write2", found, 1);
        aresetn = 1'b0;
        #1;
        check("mid_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
        check("mid_busy", busy, 0);
        exp_wr.delete();
        exp_rd.delete();
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        check("mid_err_cleared", {err_cnt, resp_err}, 0);

        rd_count = 0;
        rd_err_idx = 3;
        run(2'd2, 32'h400, 8, 1'b1, 32'h1000, 1, 32'h408, 1);
        rd_err_idx = 0;

        run(2'd3, 32'hFFFFFFFB, 4, 1'b0, 32'h5A5A5A5A, 0, 0, 0);

        repeat (5) @(negedge aclk);
        check("wr_left", exp_wr.size(), 0);
        check("rd_left", exp_rd.size(), 0);
        check("res_left", exp_res.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
